// File: rtl/frame_buffer_pkg.sv
// Shared types and helpers for the frame-granular output FIFO write scheduler.
package frame_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PASS,
    ST_DROP
  } fb_state_e;

  localparam logic [15:0] DROP_SAT   = 16'hFFFF;
  localparam logic [7:0]  FRAMES_SAT = 8'hFF;

  // True when a whole frame fits in the space left above the given fill level.
  function automatic logic frame_fits(input logic [31:0] level,
                                      input logic [31:0] depth,
                                      input logic [31:0] frame_words);
    return (level <= depth) && ((depth - level) >= frame_words);
  endfunction

endpackage

// File: rtl/fifo_level_tracker.sv
// Mirrors the output FIFO fill level: word occupancy, read-side frame counting,
// complete frames resident and the sticky empty-read error.
module fifo_level_tracker
  import frame_buffer_pkg::*;
#(
  parameter int FRAME_WORDS = 16384,
  parameter int OCC_W       = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_last,
  input  logic             rd,
  input  logic             clr_err,
  output logic [OCC_W-1:0] occupancy,
  output logic [7:0]       frames_ready,
  output logic             rd_err
);

  localparam int RC_W = $clog2(FRAME_WORDS);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic [7:0]       frames_q, frames_d;
  logic             err_q, err_d;
  logic             rd_ok;
  logic             frame_read;
  logic             frame_written;

  // A read against an empty FIFO is refused and only flags the error.
  assign rd_ok         = rd && (occ_q != '0);
  assign frame_read    = rd_ok && (rcnt_q == RC_W'(FRAME_WORDS - 1));
  assign frame_written = wr_en && wr_last;

  always_comb begin
    occ_d    = occ_q;
    rcnt_d   = rcnt_q;
    frames_d = frames_q;
    err_d    = err_q;

    if (wr_en && !rd_ok) begin
      occ_d = occ_q + 1'b1;
    end else if (!wr_en && rd_ok) begin
      occ_d = occ_q - 1'b1;
    end

    if (frame_read) begin
      rcnt_d = '0;
    end else if (rd_ok) begin
      rcnt_d = rcnt_q + 1'b1;
    end

    if (frame_written && !frame_read && (frames_q != FRAMES_SAT)) begin
      frames_d = frames_q + 1'b1;
    end else if (frame_read && !frame_written && (frames_q != 8'd0)) begin
      frames_d = frames_q - 1'b1;
    end

    if (rd && (occ_q == '0)) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= '0;
      rcnt_q   <= '0;
      frames_q <= '0;
      err_q    <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      rcnt_q   <= rcnt_d;
      frames_q <= frames_d;
      err_q    <= err_d;
    end
  end

  assign occupancy    = occ_q;
  assign frames_ready = frames_q;
  assign rd_err       = err_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Frame-granular admission into the host output FIFO: whole frames or nothing.
// Optional idle-timeout zero padding of PASS frames is enabled with `define FRAME_PAD_EN.
module frame_buffer_ctrl
  import frame_buffer_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int FRAME_WORDS = 16384,
  parameter int FIFO_DEPTH  = 65536,
  parameter int OCC_W       = 17,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              fifo_rd,
  input  logic              clr_err,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              frame_avail,
  output logic [7:0]        frames_ready,
  output logic [OCC_W-1:0]  occupancy,
  output logic [15:0]       drop_cnt,
  output logic              busy,
  output logic              rd_err
);

  localparam int WC_W = $clog2(FRAME_WORDS);

  if ((FRAME_WORDS < 2) || (TIMEOUT_CYC < 1)) begin : g_param_check
    $error("frame_buffer_ctrl: FRAME_WORDS must be >= 2 and TIMEOUT_CYC >= 1");
  end

  fb_state_e         state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic              wr_q, wr_d;
  logic              wr_last_q, wr_last_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [15:0]       drop_q, drop_d;
  logic              drop_inc;
  logic              step;
  logic [DATA_W-1:0] step_data;
  logic              last_word;
  logic              fits;

`ifdef FRAME_PAD_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              pad_q, pad_d;
  logic [15:0]       pad_frames_q, pad_frames_d;
`endif

  assign last_word = (wcnt_q == WC_W'(FRAME_WORDS - 1));
  // Count the word already on fifo_wr_en so back-to-back frames cannot overfill.
  assign fits = frame_fits(32'(occupancy) + 32'(wr_q), 32'(FIFO_DEPTH), 32'(FRAME_WORDS));

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    wr_d      = 1'b0;
    wr_last_d = 1'b0;
    din_d     = din_q;
    drop_inc  = 1'b0;
    step      = 1'b0;
    step_data = in_data;
`ifdef FRAME_PAD_EN
    idle_d       = idle_q;
    pad_d        = pad_q;
    pad_frames_d = pad_frames_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_WAIT;
      end

      ST_WAIT: begin
`ifdef FRAME_PAD_EN
        idle_d = '0;
        pad_d  = 1'b0;
`endif
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          wcnt_d = WC_W'(1);
          if (fits) begin
            state_d = ST_PASS;
            wr_d    = 1'b1;
            din_d   = in_data;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_PASS: begin
`ifdef FRAME_PAD_EN
        if (pad_q) begin
          step      = 1'b1;
          step_data = '0;
        end else if (in_valid) begin
          step   = 1'b1;
          idle_d = '0;
        end else begin
          idle_d = idle_q + 1'b1;
          if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) pad_d = 1'b1;
        end
`else
        step = in_valid;
`endif
        if (step) begin
          wr_d  = 1'b1;
          din_d = step_data;
          if (last_word) begin
            wr_last_d = 1'b1;
            wcnt_d    = '0;
            state_d   = arm ? ST_WAIT : ST_IDLE;
`ifdef FRAME_PAD_EN
            if (pad_q && (pad_frames_q != 16'hFFFF)) pad_frames_d = pad_frames_q + 1'b1;
            pad_d  = 1'b0;
            idle_d = '0;
`endif
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      ST_DROP: begin
        if (in_valid) begin
          if (last_word) begin
            drop_inc = 1'b1;
            wcnt_d   = '0;
            state_d  = arm ? ST_WAIT : ST_IDLE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    drop_d = drop_q;
    if (drop_inc) begin
      if (drop_q != DROP_SAT) drop_d = drop_q + 1'b1;
    end else if (clr_err) begin
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      wr_q      <= 1'b0;
      wr_last_q <= 1'b0;
      din_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      wr_q      <= wr_d;
      wr_last_q <= wr_last_d;
      din_q     <= din_d;
      drop_q    <= drop_d;
    end
  end

`ifdef FRAME_PAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q       <= '0;
      pad_q        <= 1'b0;
      pad_frames_q <= '0;
    end else begin
      idle_q       <= idle_d;
      pad_q        <= pad_d;
      pad_frames_q <= pad_frames_d;
    end
  end
`endif

  fifo_level_tracker #(
    .FRAME_WORDS (FRAME_WORDS),
    .OCC_W       (OCC_W)
  ) u_level (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_q),
    .wr_last      (wr_last_q),
    .rd           (fifo_rd),
    .clr_err      (clr_err),
    .occupancy    (occupancy),
    .frames_ready (frames_ready),
    .rd_err       (rd_err)
  );

  assign fifo_wr_en  = wr_q;
  assign fifo_din    = din_q;
  assign drop_cnt    = drop_q;
  assign frame_avail = (frames_ready != 8'd0);
  assign busy        = (state_q == ST_PASS) || (state_q == ST_DROP);

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Scoreboard bench for frame_buffer_ctrl with a small FIFO and short frames.
module tb_frame_buffer_ctrl;

  localparam int DW    = 24;
  localparam int FW    = 8;
  localparam int DEPTH = 20;
  localparam int OW    = 5;
  localparam int TO    = 4;

  logic          clk;
  logic          rst_n;
  logic          arm;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          fifo_rd;
  logic          clr_err;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_din;
  logic          frame_avail;
  logic [7:0]    frames_ready;
  logic [OW-1:0] occupancy;
  logic [15:0]   drop_cnt;
  logic          busy;
  logic          rd_err;

  frame_buffer_ctrl #(
    .DATA_W      (DW),
    .FRAME_WORDS (FW),
    .FIFO_DEPTH  (DEPTH),
    .OCC_W       (OW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .fifo_rd      (fifo_rd),
    .clr_err      (clr_err),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_din     (fifo_din),
    .frame_avail  (frame_avail),
    .frames_ready (frames_ready),
    .occupancy    (occupancy),
    .drop_cnt     (drop_cnt),
    .busy         (busy),
    .rd_err       (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] sb_q[$];
  int model_occ    = 0;
  int model_frames = 0;
  int model_rcnt   = 0;
  int model_drops  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_read();
    if (model_occ > 0) begin
      model_occ--;
      model_rcnt++;
      if (model_rcnt == FW) begin
        model_rcnt = 0;
        model_frames--;
      end
    end
  endtask

  task automatic do_reads(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_rd = 1'b1;
      model_read();
      tick();
    end
    fifo_rd = 1'b0;
  endtask

  // One full frame; arm drops before word index arm_off (if in range).
  task automatic send_frame(input int arm_off, input bit with_rd);
    bit admit;
    admit = (DEPTH - model_occ) >= FW;
    for (int i = 0; i < FW; i++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      fifo_rd  = with_rd;
      if (with_rd) model_read();
      if (admit) sb_q.push_back(in_data);
      if (i == arm_off) arm = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    fifo_rd  = 1'b0;
    if (admit) begin
      model_occ += FW;
      model_frames++;
    end else begin
      model_drops++;
    end
    $display("[TB] frame sent admit=%0d occ_model=%0d", admit, model_occ);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && fifo_wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("wr_unexpected", {31'b0, fifo_wr_en}, 32'd0);
      end else begin
        check_eq("wr_data", 32'(fifo_din), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; arm = 1'b0; in_valid = 1'b0; in_data = '0;
    fifo_rd = 1'b0; clr_err = 1'b0;
    tick(); tick();
    check_eq("rst_occ", 32'(occupancy), 0);
    check_eq("rst_frames", 32'(frames_ready), 0);
    check_eq("rst_avail", 32'(frame_avail), 0);
    check_eq("rst_drop", 32'(drop_cnt), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_rderr", 32'(rd_err), 0);
    check_eq("rst_wren", 32'(fifo_wr_en), 0);

    rst_n = 1'b1; arm = 1'b1;
    tick(); tick();

    send_frame(-1, 1'b0);
    tick(); tick(); tick();
    check_eq("f1_frames", 32'(frames_ready), 32'(model_frames));
    check_eq("f1_avail", 32'(frame_avail), 1);
    check_eq("f1_occ", 32'(occupancy), 32'(model_occ));
    check_eq("f1_busy", 32'(busy), 0);

    send_frame(-1, 1'b0);
    tick(); tick(); tick();
    check_eq("f2_occ", 32'(occupancy), 16);
    check_eq("f2_frames", 32'(frames_ready), 32'(model_frames));

    send_frame(-1, 1'b0);
    tick(); tick(); tick();
    check_eq("f3_drop", 32'(drop_cnt), 32'(model_drops));
    check_eq("f3_occ", 32'(occupancy), 32'(model_occ));

    do_reads(FW);
    tick(); tick();
    check_eq("rd8_occ", 32'(occupancy), 8);
    check_eq("rd8_frames", 32'(frames_ready), 32'(model_frames));

    send_frame(-1, 1'b1);
    tick(); tick(); tick();
    check_eq("rdwr_occ", 32'(occupancy), 32'(model_occ));
    check_eq("rdwr_frames", 32'(frames_ready), 32'(model_frames));

    send_frame(3, 1'b0);
    tick(); tick(); tick();
    check_eq("armoff_occ", 32'(occupancy), 32'(model_occ));
    check_eq("armoff_frames", 32'(frames_ready), 32'(model_frames));
    check_eq("armoff_busy", 32'(busy), 0);

    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    check_eq("idle_occ", 32'(occupancy), 32'(model_occ));

    do_reads(2 * FW);
    tick(); tick();
    check_eq("drain_occ", 32'(occupancy), 0);
    check_eq("drain_frames", 32'(frames_ready), 32'(model_frames));
    check_eq("drain_rderr", 32'(rd_err), 0);

    do_reads(1);
    tick();
    check_eq("empty_rderr", 32'(rd_err), 1);
    check_eq("empty_occ", 32'(occupancy), 0);

    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    check_eq("clr_rderr", 32'(rd_err), 0);
    check_eq("clr_drop", 32'(drop_cnt), 0);

    arm = 1'b1;
    tick(); tick();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'($urandom);
      sb_q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    check_eq("mid_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_occ", 32'(occupancy), 0);
    check_eq("arst_wren", 32'(fifo_wr_en), 0);
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_frames", 32'(frames_ready), 0);
    sb_q.delete();
    model_occ = 0; model_frames = 0; model_rcnt = 0;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef FRAME_PAD_EN
    arm = 1'b1;
    tick(); tick();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = DW'($urandom);
      sb_q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 5; i < FW; i++) sb_q.push_back('0);
    model_occ = FW;
    model_frames = 1;
    for (int i = 0; i < 15; i++) tick();
    check_eq("pad_frames", 32'(frames_ready), 32'(model_frames));
    check_eq("pad_occ", 32'(occupancy), 32'(model_occ));
    check_eq("pad_busy", 32'(busy), 0);
`endif

    check_eq("sb_empty", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
